clk_div_ctrl: RTL and testbench

//  Run-time configuration controller for one clk_div instance. Accepts ratio-change requests over a valid/ready handshake.

---
 rtl/clk_div_ctrl_pkg.sv | 26 ++
 rtl/clk_div_ctrl_cnt.sv | 38 +++
 rtl/clk_div_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl_pkg
//   Shared definitions for the clk_div run-time configuration controller:
//   FSM state encoding, default ratio bus width and the ratio range check.
// -----------------------------------------------------------------------------
package clk_div_ctrl_pkg;

  localparam int unsigned RATIO_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,  // waiting for a request
    ST_DRAIN  = 3'd1,  // waiting for the divided clock's low phase
    ST_GATE   = 3'd2,  // divider enable held low
    ST_LOAD   = 3'd3,  // new ratio presented to the divider
    ST_SETTLE = 3'd4   // divider re-enabled, waiting one output period
  } state_e;

  // Inclusive range check; arguments are zero-extended by the caller so the
  // function works for any ratio bus width up to 64 bits.
  function automatic logic ratio_in_range(input logic [63:0] ratio,
                                          input logic [63:0] min_ratio,
                                          input logic [63:0] max_ratio);
    return (ratio >= min_ratio) && (ratio <= max_ratio);
  endfunction

endpackage

// File: rtl/clk_div_ctrl_cnt.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl_cnt
//   Loadable down-counter with zero flag. Loading takes priority; otherwise
//   the counter decrements until it reaches zero and then holds.
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset (counter cleared to 0)
//   i_load      load i_load_val this cycle
//   i_load_val  value to load
//   o_zero      counter currently equals zero
// -----------------------------------------------------------------------------
module clk_div_ctrl_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//   Run-time configuration controller for one clk_div instance. Takes ratio
//   change requests over valid/ready, and applies them glitch-free: wait for
//   the divided clock to fall, gate the divider, load the ratio, re-enable and
//   wait one full output period before reporting lock.
//
// Optional feature: define CLK_DIV_CTRL_TIMEOUT_EN to bound the wait for the
//   divided clock's falling edge to DRAIN_TO cycles; on expiry o_drain_to
//   pulses and the change is forced. Without it, o_drain_to is tied low.
//
// Ports
//   i_ref_clk    sole clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req_valid  ratio-change request valid
//   i_req_ratio  requested ratio, sampled on accept
//   o_req_ready  high only in IDLE
//   o_req_err    1-cycle pulse: accepted ratio out of [MIN_RATIO,MAX_RATIO]
//   i_div_clk    feedback from clk_div o_div_clk
//   o_clk_en     to clk_div i_clk_en
//   o_div_ratio  to clk_div i_div_ratio
//   o_locked     divider running at o_div_ratio and settled
//   o_busy       FSM not in IDLE
//   o_drain_to   1-cycle pulse on drain timeout
// -----------------------------------------------------------------------------
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned RATIO_W     = RATIO_W_DEF,
  parameter int unsigned MIN_RATIO   = 2,
  parameter int unsigned MAX_RATIO   = 1024,
  parameter int unsigned RESET_RATIO = 2,
  parameter int unsigned GATE_CYC    = 2,
  parameter int unsigned DRAIN_TO    = 2048
) (
  input  logic               i_ref_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  input  logic [RATIO_W-1:0] i_req_ratio,
  output logic               o_req_ready,
  output logic               o_req_err,
  input  logic               i_div_clk,
  output logic               o_clk_en,
  output logic [RATIO_W-1:0] o_div_ratio,
  output logic               o_locked,
  output logic               o_busy,
  output logic               o_drain_to
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [RATIO_W-1:0] r_shadow;
  logic [RATIO_W-1:0] r_div_ratio;
  logic               r_clk_en;
  logic               r_locked;
  logic               r_req_err;
  logic               r_div_clk_prev;

  logic               w_accept;
  logic               w_in_range;
  logic               w_fall;
  logic               w_cnt_zero;
  logic               w_cnt_load;
  logic [RATIO_W-1:0] w_cnt_val;
  logic               w_clk_en_nxt;
  logic               w_locked_nxt;
  logic               w_req_err_nxt;
  logic               w_ratio_load;
  logic               w_drain_to_nxt;

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_in_range  = ratio_in_range(64'(i_req_ratio), 64'(MIN_RATIO), 64'(MAX_RATIO));
  assign w_fall      = r_div_clk_prev && !i_div_clk;

  // One counter serves the drain timeout, the gate hold and the settle period;
  // those phases never overlap, so each phase loads it on entry.
  clk_div_ctrl_cnt #(.W(RATIO_W)) u_cnt (
    .i_clk      (i_ref_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .o_zero     (w_cnt_zero)
  );

  // NOTE: every output of this block is given a default before the case
  // statement, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_clk_en_nxt   = r_clk_en;
    w_locked_nxt   = r_locked;
    w_req_err_nxt  = 1'b0;
    w_ratio_load   = 1'b0;
    w_drain_to_nxt = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_val      = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!w_in_range) begin
            w_req_err_nxt = 1'b1;
          end else if (!((i_req_ratio == r_div_ratio) && r_locked)) begin
            if (!r_clk_en) begin
              // Divider is stopped: nothing to drain, load straight away.
              w_state_nxt = ST_LOAD;
            end else begin
              w_state_nxt  = ST_DRAIN;
              w_locked_nxt = 1'b0;
              w_cnt_load   = 1'b1;
              w_cnt_val    = RATIO_W'(DRAIN_TO - 1);
            end
          end
        end
      end

      ST_DRAIN: begin
        // Gating right after the divided clock falls keeps the low phase
        // intact and avoids a runt pulse on the divider output.
        if (w_fall) begin
          w_state_nxt  = ST_GATE;
          w_clk_en_nxt = 1'b0;
          w_cnt_load   = 1'b1;
          w_cnt_val    = RATIO_W'(GATE_CYC - 1);
        end
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
        else if (w_cnt_zero) begin
          w_drain_to_nxt = 1'b1;
          w_state_nxt    = ST_GATE;
          w_clk_en_nxt   = 1'b0;
          w_cnt_load     = 1'b1;
          w_cnt_val      = RATIO_W'(GATE_CYC - 1);
        end
`endif
      end

      ST_GATE: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // Ratio and enable change on the same edge; the settle count covers
        // exactly one period of the new ratio.
        w_ratio_load = 1'b1;
        w_clk_en_nxt = 1'b1;
        w_state_nxt  = ST_SETTLE;
        w_cnt_load   = 1'b1;
        w_cnt_val    = r_shadow - 1'b1;
      end

      ST_SETTLE: begin
        if (w_cnt_zero) begin
          w_state_nxt  = ST_IDLE;
          w_locked_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_shadow       <= RATIO_W'(RESET_RATIO);
      r_div_ratio    <= RATIO_W'(RESET_RATIO);
      r_clk_en       <= 1'b0;
      r_locked       <= 1'b0;
      r_req_err      <= 1'b0;
      r_div_clk_prev <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_clk_en       <= w_clk_en_nxt;
      r_locked       <= w_locked_nxt;
      r_req_err      <= w_req_err_nxt;
      r_div_clk_prev <= i_div_clk;
      if (w_accept) begin
        r_shadow <= i_req_ratio;
      end
      if (w_ratio_load) begin
        r_div_ratio <= r_shadow;
      end
    end
  end

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
  logic r_drain_to;

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drain_to <= 1'b0;
    end else begin
      r_drain_to <= w_drain_to_nxt;
    end
  end

  assign o_drain_to = r_drain_to;
`else
  assign o_drain_to = 1'b0;
`endif

  assign o_clk_en    = r_clk_en;
  assign o_div_ratio = r_div_ratio;
  assign o_locked    = r_locked;
  assign o_req_err   = r_req_err;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
//   Bench for clk_div_ctrl driving a behavioural clk_div. Expectations come
//   from a request-level model: range check, no-op rule, and the timeline
//   drain (first divided-clock fall) + gate + load + one output period.
//   Build with CLK_DIV_CTRL_TIMEOUT_EN to exercise the drain timeout.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

  localparam int unsigned MIN_R   = 2;
  localparam int unsigned MAX_R   = 1024;
  localparam int unsigned RESET_R = 2;
  localparam int unsigned GATE_C  = 2;
  localparam int unsigned DRAIN_T = 2048;

  logic        ref_clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_ratio;
  logic        req_ready;
  logic        req_err;
  logic        div_clk;
  logic        clk_en;
  logic [31:0] div_ratio;
  logic        locked;
  logic        busy;
  logic        drain_to;
  logic        force_low;

  int errors = 0;
  int checks = 0;

  // Request-level model of the controller's visible configuration.
  logic [31:0] m_ratio;
  logic        m_locked;
  logic        m_clk_en;

  always #5 ref_clk = ~ref_clk;

  clk_div_ctrl dut (
    .i_ref_clk   (ref_clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_ratio (req_ratio),
    .o_req_ready (req_ready),
    .o_req_err   (req_err),
    .i_div_clk   (div_clk),
    .o_clk_en    (clk_en),
    .o_div_ratio (div_ratio),
    .o_locked    (locked),
    .o_busy      (busy),
    .o_drain_to  (drain_to)
  );

  // Behavioural clk_div: period of div_ratio reference cycles while enabled,
  // output low and phase reset while disabled.
  logic [31:0] dcnt;
  logic        dv;
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= '0;
      dv   <= 1'b0;
    end else if (!clk_en) begin
      dcnt <= '0;
      dv   <= 1'b0;
    end else begin
      dcnt <= (dcnt >= div_ratio - 1) ? 32'd0 : dcnt + 32'd1;
      dv   <= (dcnt < (div_ratio >> 1));
    end
  end
  assign div_clk = dv && !force_low;

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_ratio = '0;
    force_low = 1'b0;
    repeat (3) @(negedge ref_clk);
    rst_n = 1'b1;
    @(negedge ref_clk);
    m_ratio  = RESET_R;
    m_locked = 1'b0;
    m_clk_en = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (clk_en !== 1'b0 || div_ratio !== RESET_R || locked !== 1'b0 || req_ready !== 1'b1 ||
        req_err !== 1'b0 || busy !== 1'b0 || drain_to !== 1'b0) begin
      errors++;
      $display("FAIL %s: got en=%b ratio=%0d lock=%b rdy=%b err=%b busy=%b dto=%b want en=0 ratio=%0d lock=0 rdy=1 err=0 busy=0 dto=0",
               tag, clk_en, div_ratio, locked, req_ready, req_err, busy, drain_to, RESET_R);
    end
  endtask

  task automatic measure_period(input logic [31:0] n, input string tag);
    logic prev;
    int   c;
    int   first;
    int   period;
    first  = -1;
    period = -1;
    prev   = div_clk;
    c      = 0;
    while (period < 0 && c < int'(4 * n) + 8) begin
      @(negedge ref_clk);
      c++;
      if (!prev && div_clk) begin
        if (first < 0) first = c;
        else period = c - first;
      end
      prev = div_clk;
    end
    checks++;
    if (period != int'(n)) begin
      errors++;
      $display("FAIL %s period: got %0d want %0d", tag, period, n);
    end
  endtask

  // Issues one request from IDLE (at a negedge) and follows it to completion.
  task automatic do_request(input logic [31:0] ratio, input string tag);
    logic in_range;
    logic is_noop;
    logic vm1;
    logic vm2;
    int   c;
    int   gate_c;
    int   rise_c;
    int   bound;
    in_range = (ratio >= MIN_R) && (ratio <= MAX_R);
    is_noop  = in_range && (ratio == m_ratio) && m_locked;

    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: got %b want 1", tag, req_ready);
    end
    req_valid = 1'b1;
    req_ratio = ratio;
    vm1       = div_clk;
    vm2       = 1'b0;
    @(negedge ref_clk);
    req_valid = 1'b0;

    if (!in_range) begin
      checks++;
      if (req_err !== 1'b1 || div_ratio !== m_ratio || locked !== m_locked || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s err_pulse: got err=%b ratio=%0d lock=%b rdy=%b want err=1 ratio=%0d lock=%b rdy=1",
                 tag, req_err, div_ratio, locked, req_ready, m_ratio, m_locked);
      end
      @(negedge ref_clk);
      checks++;
      if (req_err !== 1'b0) begin
        errors++;
        $display("FAIL %s err_width: got %b want 0", tag, req_err);
      end
      return;
    end

    checks++;
    if (req_err !== 1'b0) begin
      errors++;
      $display("FAIL %s no_err: got %b want 0", tag, req_err);
    end

    if (is_noop) begin
      checks++;
      if (locked !== 1'b1 || div_ratio !== m_ratio || clk_en !== m_clk_en || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s noop: got lock=%b ratio=%0d en=%b rdy=%b want lock=1 ratio=%0d en=%b rdy=1",
                 tag, locked, div_ratio, clk_en, req_ready, m_ratio, m_clk_en);
      end
      return;
    end

    checks++;
    if (busy !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL %s start: got busy=%b lock=%b want busy=1 lock=0", tag, busy, locked);
    end

    c = 0;
    if (!m_clk_en) begin
      rise_c = 1;
    end else begin
      // Gate starts on the edge that first sees the divided clock go 1 -> 0.
      bound  = 2 * int'(m_ratio) + 4;
      gate_c = -1;
      while (gate_c < 0) begin
        if (c >= 1 && vm2 && !vm1) gate_c = c;
        checks++;
        if (clk_en !== (gate_c < 0)) begin
          errors++;
          $display("FAIL %s drain_en at cycle %0d: got %b want %b", tag, c, clk_en, gate_c < 0);
        end
        if (gate_c < 0) begin
          if (c > bound) begin
            checks++;
            errors++;
            $display("FAIL %s drain_wait: got no gate after %0d cycles want at most %0d", tag, c, bound);
            return;
          end
          vm2 = vm1;
          vm1 = div_clk;
          @(negedge ref_clk);
          c++;
        end
      end
      rise_c = gate_c + int'(GATE_C) + 1;
    end

    while (c < rise_c) begin
      checks++;
      if (clk_en !== 1'b0 || div_ratio !== m_ratio) begin
        errors++;
        $display("FAIL %s gated at cycle %0d: got en=%b ratio=%0d want en=0 ratio=%0d",
                 tag, c, clk_en, div_ratio, m_ratio);
      end
      @(negedge ref_clk);
      c++;
    end

    checks++;
    if (clk_en !== 1'b1 || div_ratio !== ratio || locked !== 1'b0) begin
      errors++;
      $display("FAIL %s reenable: got en=%b ratio=%0d lock=%b want en=1 ratio=%0d lock=0",
               tag, clk_en, div_ratio, locked, ratio);
    end
    repeat (int'(ratio) - 1) @(negedge ref_clk);
    checks++;
    if (locked !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s settle_end: got lock=%b busy=%b want lock=0 busy=1", tag, locked, busy);
    end
    @(negedge ref_clk);
    checks++;
    if (locked !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0 || clk_en !== 1'b1 || div_ratio !== ratio) begin
      errors++;
      $display("FAIL %s lock: got lock=%b rdy=%b busy=%b en=%b ratio=%0d want lock=1 rdy=1 busy=0 en=1 ratio=%0d",
               tag, locked, req_ready, busy, clk_en, div_ratio, ratio);
    end
    m_ratio  = ratio;
    m_locked = 1'b1;
    m_clk_en = 1'b1;
    measure_period(ratio, tag);
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_values("reset");
  endtask

  task automatic test_first_load();
    do_request(32'd4, "first_load");
  endtask

  task automatic test_ratio_change();
    do_request(32'd5, "change_5");
  endtask

  task automatic test_range_err();
    do_request(32'd1, "err_1");
    do_request(32'd2000, "err_2000");
  endtask

  task automatic test_noop();
    do_request(32'd3, "to_3");
    do_request(32'd3, "noop_3");
    repeat (3) @(negedge ref_clk);
    checks++;
    if (locked !== 1'b1 || clk_en !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL noop_hold: got lock=%b en=%b busy=%b want lock=1 en=1 busy=0", locked, clk_en, busy);
    end
  endtask

  task automatic test_boundaries();
    do_request(32'd0, "err_0");
    do_request(MAX_R + 1, "err_max_plus1");
    do_request(MAX_R, "max");
    do_request(MIN_R, "min");
  endtask

  task automatic test_random();
    logic [31:0] r;
    int          kind;
    for (int i = 0; i < 14; i++) begin
      kind = int'($urandom_range(0, 5));
      if (kind == 0)      r = ($urandom_range(0, 1) == 0) ? $urandom_range(0, MIN_R - 1) : $urandom_range(MAX_R + 1, MAX_R + 500);
      else if (kind == 1) r = m_ratio;
      else                r = $urandom_range(MIN_R, 16);
      do_request(r, $sformatf("rand%0d_r%0d", i, r));
    end
  endtask

  task automatic test_reset_in_settle();
    apply_reset();
    req_valid = 1'b1;
    req_ratio = 32'd8;
    @(negedge ref_clk);
    req_valid = 1'b0;
    repeat (2) @(negedge ref_clk);
    checks++;
    if (busy !== 1'b1 || clk_en !== 1'b1 || locked !== 1'b0 || div_ratio !== 32'd8) begin
      errors++;
      $display("FAIL settle_setup: got busy=%b en=%b lock=%b ratio=%0d want busy=1 en=1 lock=0 ratio=8",
               busy, clk_en, locked, div_ratio);
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset_in_settle");
    @(negedge ref_clk);
    rst_n = 1'b1;
    @(negedge ref_clk);
    m_ratio  = RESET_R;
    m_locked = 1'b0;
    m_clk_en = 1'b0;
  endtask

  task automatic test_drain_stall();
    int c;
    int seen;
    apply_reset();
    do_request(32'd6, "stall_setup");
    force_low = 1'b1;
    repeat (2) @(negedge ref_clk);
    req_valid = 1'b1;
    req_ratio = 32'd9;
    @(negedge ref_clk);
    req_valid = 1'b0;
    c    = 0;
    seen = -1;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    while (seen < 0 && c <= int'(DRAIN_T) + 8) begin
      if (drain_to === 1'b1) seen = c;
      else begin
        @(negedge ref_clk);
        c++;
      end
    end
    checks++;
    if (seen != int'(DRAIN_T)) begin
      errors++;
      $display("FAIL drain_timeout_cycle: got %0d want %0d", seen, DRAIN_T);
    end
    checks++;
    if (clk_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_timeout_gate: got en=%b busy=%b want en=0 busy=1", clk_en, busy);
    end
    @(negedge ref_clk);
    checks++;
    if (drain_to !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout_width: got %b want 0", drain_to);
    end
`else
    repeat (DRAIN_T + 64) begin
      if (drain_to !== 1'b0 && seen < 0) seen = c;
      @(negedge ref_clk);
      c++;
    end
    checks++;
    if (seen >= 0 || busy !== 1'b1 || clk_en !== 1'b1 || locked !== 1'b0 || div_ratio !== 32'd6) begin
      errors++;
      $display("FAIL drain_stall: got dto_at=%0d busy=%b en=%b lock=%b ratio=%0d want dto_at=-1 busy=1 en=1 lock=0 ratio=6",
               seen, busy, clk_en, locked, div_ratio);
    end
`endif
    force_low = 1'b0;
    apply_reset();
    check_reset_values("reset_after_stall");
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_ratio = '0;
    force_low = 1'b0;
    test_reset();
    test_first_load();
    test_ratio_change();
    test_range_err();
    test_noop();
    test_boundaries();
    test_random();
    test_reset_in_settle();
    test_drain_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no completion want completion before 5 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
